pc_stack_unit: RTL and testbench
================================

Name: pc_stack_unit

Overview:
Parametrised program counter for the next-generation sequencer.
- Supports increment, absolute load (jump), signed relative branch, and call/return through an internal hardware return stack.
- Drives the shared address bus through a tri-state output.
- Also exposes an always-driven copy of the PC plus stack status flags to the control unit.

Parameters:
WIDTH, 16, address/PC width in bits
DEPTH, 4, return-stack entries (power of two, >=2)
RESET_VECTOR, 0, PC value after reset
STEP, 1, increment amount per sequential advance

Ports:
PC_clock  input  1  rising-edge clock
PC_reset  input  1  asynchronous, active-high reset
PC_stall  input  1  freezes PC, stack and flags when high
PC_increment  input  1  advance PC by STEP
PC_load  input  1  PC <= PC_data_in (absolute jump)
PC_branch  input  1  PC <= PC + signed PC_data_in
PC_call  input  1  push PC+STEP, PC <= PC_data_in
PC_return  input  1  pop stack into PC
PC_data_in  input  WIDTH  jump target / branch offset (two's complement)
PC_output_en  input  1  enables tri-state bus drive
PC_address_out  output  WIDTH  bus address; high-Z when PC_output_en=0
PC_value  output  WIDTH  current PC, always driven
PC_stack_count  output  $clog2(DEPTH)+1  number of valid stack entries
PC_stack_full  output  1  count==DEPTH
PC_stack_empty  output  1  count==0
PC_overflow  output  1  sticky: call attempted while full
PC_underflow  output  1  sticky: return attempted while empty

Behaviour:
- Reset (asynchronous, any time, including mid-operation): PC=RESET_VECTOR, stack count=0, overflow=0, underflow=0, empty=1, full=0. Stack contents are don't-care.
- All updates occur on the rising PC_clock edge. New PC is visible on PC_value/PC_address_out the cycle after the command (1-cycle latency).
- PC_stall=1: no state changes; all command inputs are ignored.
- Command priority when several are high: load > call > return > branch > increment. Only the winner executes; losers are dropped with no side effects.
- No command active: PC holds.
- Increment: PC <= PC+STEP, modulo 2^WIDTH (max value wraps to 0 with no flag).
- Branch: PC <= PC + PC_data_in, sign-extended, modulo 2^WIDTH.
- Call, not full:
  - stack[count] <= PC+STEP (mod 2^WIDTH), count+1, PC <= PC_data_in.
  - Full-but-not-overflowed, i.e. count==DEPTH: see next item.
- Call while full: PC holds, stack unchanged, overflow <= 1.
- Return, not empty: PC <= stack[count-1], count-1.
- Return while empty: PC holds, underflow <= 1.
- Overflow/underflow stay at 1 until reset.
- Full/empty/count are registered state, consistent with the stack pointer every cycle.
- PC_address_out = PC_value when PC_output_en=1, else all bits Z. The enable is combinational: no clock latency, and it does not affect internal state.

Decomposition:
- Shared package holds:
  - opcode-priority localparams (CMD_LOAD, CMD_CALL, CMD_RETURN, CMD_BRANCH, CMD_INC, CMD_NONE)
  - the stack-count width function
- One natural sub-module: pc_return_stack (LIFO with DEPTH and WIDTH parameters, push/pop, full/empty/count, overflow/underflow detection).
- Output drive reuses the team's tri_state_buffer, instantiated at WIDTH bits.

Test Plan:
1. Reset and increment wrap:
   - Assert PC_reset asynchronously mid-cycle -> PC_value=0 immediately.
   - Preload 16'hFFFE, then 3 increments -> 16'hFFFF, 16'h0000, 16'h0001.
2. Branch:
   - PC=16'h0010, PC_data_in=16'hFFFC (-4), branch -> 16'h000C.
   - Then data_in=16'h0008 -> 16'h0014.
3. Nested call/return, DEPTH=4:
   - From PC=16'h0100, call 16'h0200, then call 16'h0300 -> count=2.
   - Return -> PC=16'h0201; return -> PC=16'h0101; empty=1.
4. Overflow/underflow:
   - 5 calls from an empty stack -> 5th leaves PC and stack unchanged, full=1, overflow=1.
   - Reset, then return -> PC holds at 0, underflow=1, sticky over 10 idle cycles.
5. Priority and stall:
   - load+call+increment together with data_in=16'h0040 -> PC=16'h0040, count unchanged.
   - With PC_stall=1, an increment holds PC for 3 cycles.
6. Tri-state:
   - PC_output_en=0 -> PC_address_out all Z while PC_value tracks increments.
   - Raise enable -> bus equals PC_value in the same cycle.

Source files
------------

// File: rtl/pc_stack_unit_pkg.sv
// Shared definitions for the program-counter unit: command priority codes and
// the sizing helper for the return-stack occupancy count.
package pc_stack_unit_pkg;

    typedef logic [2:0] cmd_t;

    // Larger code = higher priority; decode_cmd resolves simultaneous requests.
    localparam cmd_t CMD_NONE   = 3'd0;
    localparam cmd_t CMD_INC    = 3'd1;
    localparam cmd_t CMD_BRANCH = 3'd2;
    localparam cmd_t CMD_RETURN = 3'd3;
    localparam cmd_t CMD_CALL   = 3'd4;
    localparam cmd_t CMD_LOAD   = 3'd5;

    // Count must reach DEPTH itself, hence one bit more than the index.
    function automatic int stack_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic cmd_t decode_cmd(
        input logic load,
        input logic call,
        input logic ret,
        input logic branch,
        input logic inc
    );
        if (load)        return CMD_LOAD;
        else if (call)   return CMD_CALL;
        else if (ret)    return CMD_RETURN;
        else if (branch) return CMD_BRANCH;
        else if (inc)    return CMD_INC;
        else             return CMD_NONE;
    endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// Command and status bundle between the control unit (master) and the
// program-counter unit (slave).
interface pc_stack_unit_if
    import pc_stack_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    logic                                  PC_stall;
    logic                                  PC_increment;
    logic                                  PC_load;
    logic                                  PC_branch;
    logic                                  PC_call;
    logic                                  PC_return;
    logic [WIDTH-1:0]                      PC_data_in;
    logic                                  PC_output_en;
    logic [WIDTH-1:0]                      PC_value;
    logic [stack_count_width(DEPTH)-1:0]   PC_stack_count;
    logic                                  PC_stack_full;
    logic                                  PC_stack_empty;
    logic                                  PC_overflow;
    logic                                  PC_underflow;

    modport master (
        output PC_stall, PC_increment, PC_load, PC_branch, PC_call, PC_return,
        output PC_data_in, PC_output_en,
        input  PC_value, PC_stack_count, PC_stack_full, PC_stack_empty,
        input  PC_overflow, PC_underflow
    );

    modport slave (
        input  PC_stall, PC_increment, PC_load, PC_branch, PC_call, PC_return,
        input  PC_data_in, PC_output_en,
        output PC_value, PC_stack_count, PC_stack_full, PC_stack_empty,
        output PC_overflow, PC_underflow
    );
endinterface

// File: rtl/pc_return_stack.sv
// Hardware return-address LIFO with registered occupancy flags and sticky
// overflow/underflow detection. The top entry is readable combinationally.
module pc_return_stack
    import pc_stack_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int CW   = stack_count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_reg, count_next;
    logic             full_reg, empty_reg;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;
    logic             do_push, do_pop;
    logic [AW-1:0]    top_idx;

    // Refused push/pop leave contents and count alone; only the sticky flag moves.
    always_comb begin
        do_push        = push && !full_reg;
        do_pop         = pop && !push && !empty_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg  | (push && full_reg);
        underflow_next = underflow_reg | (pop && !push && empty_reg);
        if (do_push)
            count_next = count_reg + CW'(1);
        else if (do_pop)
            count_next = count_reg - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg     <= '0;
            full_reg      <= 1'b0;
            empty_reg     <= 1'b1;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            full_reg      <= (count_next == CW'(DEPTH));
            empty_reg     <= (count_next == '0);
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[count_reg[AW-1:0]] <= push_data;
    end

    // With count==DEPTH the low bits wrap to 0, so subtracting one still lands on the top slot.
    assign top_idx   = count_reg[AW-1:0] - AW'(1);
    assign top_data  = mem[top_idx];
    assign count     = count_reg;
    assign full      = full_reg;
    assign empty     = empty_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: rtl/tri_state_buffer.sv
// Parametrised tri-state driver: passes data through when enabled, else high-Z.
module tri_state_buffer #(
    parameter int WIDTH = 16
) (
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    output wire  [WIDTH-1:0] data_out
);
    assign data_out = en ? data_in : {WIDTH{1'bz}};
endmodule

// File: rtl/pc_stack_unit.sv
// Sequencer program counter: increment, jump, relative branch and call/return
// through an internal return stack, with a tri-state drive onto the address bus.
module pc_stack_unit
    import pc_stack_unit_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               DEPTH        = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               STEP         = 1
) (
    input  logic              PC_clock,
    input  logic              PC_reset,
    pc_stack_unit_if.slave    pc_bus,
    output wire  [WIDTH-1:0]  PC_address_out
);
    localparam int               CW     = stack_count_width(DEPTH);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    cmd_t             cmd;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [WIDTH-1:0] return_addr;
    logic [WIDTH-1:0] stack_top;
    logic             stack_push, stack_pop;
    logic [CW-1:0]    stack_count;
    logic             stack_full, stack_empty;
    logic             stack_overflow, stack_underflow;

    assign return_addr = pc_reg + STEP_W;

    // Stall masks every command so neither the PC nor the stack can move.
    always_comb begin
        cmd        = pc_bus.PC_stall ? CMD_NONE
                   : decode_cmd(pc_bus.PC_load, pc_bus.PC_call, pc_bus.PC_return,
                                pc_bus.PC_branch, pc_bus.PC_increment);
        pc_next    = pc_reg;
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        case (cmd)
            CMD_LOAD:   pc_next = pc_bus.PC_data_in;
            CMD_CALL: begin
                stack_push = 1'b1;
                if (!stack_full)
                    pc_next = pc_bus.PC_data_in;
            end
            CMD_RETURN: begin
                stack_pop = 1'b1;
                if (!stack_empty)
                    pc_next = stack_top;
            end
            // Same-width add already gives two's-complement wrap for the signed offset.
            CMD_BRANCH: pc_next = pc_reg + pc_bus.PC_data_in;
            CMD_INC:    pc_next = return_addr;
            default:    pc_next = pc_reg;
        endcase
    end

    always_ff @(posedge PC_clock or posedge PC_reset) begin
        if (PC_reset)
            pc_reg <= RESET_VECTOR;
        else
            pc_reg <= pc_next;
    end

    pc_return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (PC_clock),
        .rst       (PC_reset),
        .push      (stack_push),
        .pop       (stack_pop),
        .push_data (return_addr),
        .top_data  (stack_top),
        .count     (stack_count),
        .full      (stack_full),
        .empty     (stack_empty),
        .overflow  (stack_overflow),
        .underflow (stack_underflow)
    );

    tri_state_buffer #(
        .WIDTH (WIDTH)
    ) u_bus_drv (
        .en       (pc_bus.PC_output_en),
        .data_in  (pc_reg),
        .data_out (PC_address_out)
    );

    assign pc_bus.PC_value       = pc_reg;
    assign pc_bus.PC_stack_count = stack_count;
    assign pc_bus.PC_stack_full  = stack_full;
    assign pc_bus.PC_stack_empty = stack_empty;
    assign pc_bus.PC_overflow    = stack_overflow;
    assign pc_bus.PC_underflow   = stack_underflow;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: a table of commands with hand-computed expectations
// queued per transaction, plus hand-written reset, underflow, stall and bus sequences.
module tb_pc_stack_unit;

    logic       PC_clock = 1'b0;
    logic       PC_reset;
    wire [15:0] addr_bus;

    // Weak pull lets a released bus read as all ones instead of floating.
    pullup (addr_bus);

    pc_stack_unit_if #(.WIDTH(16), .DEPTH(4)) bus ();

    pc_stack_unit #(
        .WIDTH        (16),
        .DEPTH        (4),
        .RESET_VECTOR (16'h0000),
        .STEP         (1)
    ) dut (
        .PC_clock       (PC_clock),
        .PC_reset       (PC_reset),
        .pc_bus         (bus),
        .PC_address_out (addr_bus)
    );

    always #5 PC_clock = ~PC_clock;

    typedef struct {
        logic        stall, inc, load, branch, call, ret;
        logic [15:0] data;
        logic [15:0] exp_pc;
        int          exp_cnt;
        logic        exp_ovf, exp_unf;
    } vec_t;

    typedef struct {
        int          idx;
        logic [15:0] pc;
        int          cnt;
        logic        ovf, unf;
    } exp_t;

    localparam int NVEC = 32;
    vec_t vecs [NVEC];
    exp_t sb_q [$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic s, input logic i, input logic l,
                                input logic b, input logic c, input logic r,
                                input logic [15:0] d, input logic [15:0] p,
                                input int n, input logic o, input logic u);
        vec_t v;
        v.stall = s; v.inc = i; v.load = l; v.branch = b; v.call = c; v.ret = r;
        v.data = d; v.exp_pc = p; v.exp_cnt = n; v.exp_ovf = o; v.exp_unf = u;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [15:0] pc, input int cnt,
                               input logic o, input logic u);
        chk({tag, " pc"},    32'(bus.PC_value), 32'(pc));
        chk({tag, " count"}, 32'(bus.PC_stack_count), 32'(cnt));
        chk({tag, " full"},  32'(bus.PC_stack_full), 32'(cnt == 4));
        chk({tag, " empty"}, 32'(bus.PC_stack_empty), 32'(cnt == 0));
        chk({tag, " ovf"},   32'(bus.PC_overflow), 32'(o));
        chk({tag, " unf"},   32'(bus.PC_underflow), 32'(u));
        if (bus.PC_output_en)
            chk({tag, " bus"}, 32'(addr_bus), 32'(pc));
    endtask

    task automatic drive(input vec_t v);
        bus.PC_stall     = v.stall;
        bus.PC_increment = v.inc;
        bus.PC_load      = v.load;
        bus.PC_branch    = v.branch;
        bus.PC_call      = v.call;
        bus.PC_return    = v.ret;
        bus.PC_data_in   = v.data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        PC_reset = 1'b1;
        drive(mk(0,0,0,0,0,0, 16'h0000, 16'h0000, 0, 0, 0));
        bus.PC_output_en = 1'b1;
        repeat (2) @(negedge PC_clock);
        check_state("reset", 16'h0000, 0, 1'b0, 1'b0);
        PC_reset = 1'b0;

        //             stl inc ld br cl rt  data       exp_pc     cnt ovf unf
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[1]  = mk(0, 0, 1, 0, 0, 0, 16'hFFFE, 16'hFFFE, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 0, 16'h0000, 16'hFFFF, 0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0001, 0, 0, 0);
        vecs[5]  = mk(0, 0, 1, 0, 0, 0, 16'h0010, 16'h0010, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 1, 0, 0, 16'hFFFC, 16'h000C, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 1, 0, 0, 16'h0008, 16'h0014, 0, 0, 0);
        vecs[8]  = mk(0, 0, 1, 0, 0, 0, 16'h0100, 16'h0100, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 1, 0, 16'h0200, 16'h0200, 1, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 1, 0, 16'h0300, 16'h0300, 2, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0201, 1, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0101, 0, 0, 0);
        vecs[13] = mk(0, 1, 1, 0, 1, 0, 16'h0040, 16'h0040, 0, 0, 0);
        vecs[14] = mk(0, 1, 0, 1, 1, 1, 16'h0500, 16'h0500, 1, 0, 0);
        vecs[15] = mk(0, 1, 0, 1, 0, 1, 16'h0003, 16'h0041, 0, 0, 0);
        vecs[16] = mk(0, 1, 0, 1, 0, 0, 16'h0003, 16'h0044, 0, 0, 0);
        vecs[17] = mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0044, 0, 0, 0);
        vecs[18] = mk(1, 0, 1, 0, 0, 0, 16'h1234, 16'h0044, 0, 0, 0);
        vecs[19] = mk(1, 0, 0, 0, 1, 0, 16'h1234, 16'h0044, 0, 0, 0);
        vecs[20] = mk(0, 0, 0, 0, 1, 0, 16'h1000, 16'h1000, 1, 0, 0);
        vecs[21] = mk(0, 0, 0, 0, 1, 0, 16'h2000, 16'h2000, 2, 0, 0);
        vecs[22] = mk(0, 0, 0, 0, 1, 0, 16'h3000, 16'h3000, 3, 0, 0);
        vecs[23] = mk(0, 0, 0, 0, 1, 0, 16'h4000, 16'h4000, 4, 0, 0);
        vecs[24] = mk(0, 0, 0, 0, 1, 0, 16'h5000, 16'h4000, 4, 1, 0);
        vecs[25] = mk(1, 0, 0, 0, 0, 1, 16'h0000, 16'h4000, 4, 1, 0);
        vecs[26] = mk(0, 0, 0, 0, 0, 1, 16'h0000, 16'h3001, 3, 1, 0);
        vecs[27] = mk(0, 0, 0, 0, 0, 1, 16'h0000, 16'h2001, 2, 1, 0);
        vecs[28] = mk(0, 0, 0, 0, 0, 1, 16'h0000, 16'h1001, 1, 1, 0);
        vecs[29] = mk(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0045, 0, 1, 0);
        vecs[30] = mk(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0045, 0, 1, 1);
        vecs[31] = mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0045, 0, 1, 1);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge PC_clock);
            drive(vecs[i]);
            sb_q.push_back('{idx: i, pc: vecs[i].exp_pc, cnt: vecs[i].exp_cnt,
                             ovf: vecs[i].exp_ovf, unf: vecs[i].exp_unf});
            @(posedge PC_clock);
            #1;
            e = sb_q.pop_front();
            check_state($sformatf("v%0d", e.idx), e.pc, e.cnt, e.ovf, e.unf);
            $display("txn %0d: pc=%h count=%0d ovf=%b unf=%b (expect pc=%h count=%0d)",
                     e.idx, bus.PC_value, bus.PC_stack_count, bus.PC_overflow,
                     bus.PC_underflow, e.pc, e.cnt);
        end

        // Asynchronous reset mid-cycle while an increment is pending.
        @(negedge PC_clock);
        drive(mk(0,1,0,0,0,0, 16'h0000, 16'h0000, 0, 0, 0));
        @(posedge PC_clock);
        #3;
        PC_reset = 1'b1;
        #1;
        check_state("async_rst", 16'h0000, 0, 1'b0, 1'b0);
        $display("txn async_rst: pc=%h count=%0d", bus.PC_value, bus.PC_stack_count);
        @(negedge PC_clock);
        PC_reset = 1'b0;
        drive(mk(0,0,0,0,0,1, 16'h0000, 16'h0000, 0, 0, 0));
        @(posedge PC_clock);
        #1;
        check_state("underflow", 16'h0000, 0, 1'b0, 1'b1);
        $display("txn underflow: pc=%h unf=%b", bus.PC_value, bus.PC_underflow);
        @(negedge PC_clock);
        bus.PC_return = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge PC_clock);
            #1;
            check_state($sformatf("unf_hold%0d", k), 16'h0000, 0, 1'b0, 1'b1);
            $display("txn unf_hold%0d: pc=%h unf=%b", k, bus.PC_value, bus.PC_underflow);
        end

        // Stall freezes a pending increment, which then resumes.
        @(negedge PC_clock);
        bus.PC_stall     = 1'b1;
        bus.PC_increment = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge PC_clock);
            #1;
            check_state($sformatf("stall%0d", k), 16'h0000, 0, 1'b0, 1'b1);
            $display("txn stall%0d: pc=%h", k, bus.PC_value);
        end
        @(negedge PC_clock);
        bus.PC_stall = 1'b0;
        @(posedge PC_clock);
        #1;
        check_state("unstall", 16'h0001, 0, 1'b0, 1'b1);
        $display("txn unstall: pc=%h", bus.PC_value);

        // Bus released while the PC keeps counting.
        @(negedge PC_clock);
        bus.PC_output_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge PC_clock);
            #1;
            chk($sformatf("hiz%0d bus", k), 32'(addr_bus), 32'h0000FFFF);
            chk($sformatf("hiz%0d pc", k), 32'(bus.PC_value), 32'(k + 2));
            $display("txn hiz%0d: pc=%h bus=%h", k, bus.PC_value, addr_bus);
        end
        @(negedge PC_clock);
        bus.PC_increment = 1'b0;
        #2;
        bus.PC_output_en = 1'b1;
        #1;
        chk("en_rise bus", 32'(addr_bus), 32'h00000004);
        $display("txn en_rise: pc=%h bus=%h", bus.PC_value, addr_bus);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
